ahb_slave_mem: RTL and testbench

AHB_SLAVE_MEM -- requirements
Module: ahb_slave_mem

---
 rtl/ahb_slave_mem.sv | 156 +++++++++++++++
 tb/tb_ahb_slave_mem.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/ahb_slave_mem.sv
// rtl/ahb_slave_mem.sv - AHB-Lite slave backed by a 32-bit word memory with wait states and error responses
//
// Ports:
//   hclk, hresetn      clock, asynchronous active-low reset
//   hsel, haddr,       address-phase inputs from the bus (sampled when a
//   htrans, hwrite,    transfer is accepted)
//   hsize, hready
//   hwdata             write data, sampled in the data phase
//   hrdata             read data (full word during the read data phase, else 0)
//   hreadyout, hresp   slave ready and OKAY/ERROR response
module ahb_slave_mem #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_STATES = 1
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [31:0] hwdata,
    input  logic        hready,
    output logic [31:0] hrdata,
    output logic        hreadyout,
    output logic        hresp
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DATA,
        S_ERR1,
        S_ERR2
    } state_t;

    localparam logic [2:0] WS_L = 3'(WAIT_STATES);

    state_t              state_q, state_d;
    logic [2:0]          cnt_q, cnt_d;
    logic [ADDR_W+1:0]   addr_q, addr_d;
    logic                write_q, write_d;
    logic [1:0]          size_q, size_d;

    logic [31:0]         mem [0:(1<<ADDR_W)-1];
    logic [ADDR_W-1:0]   word_q;
    logic [3:0]          be;
    logic                accept;
    logic                can_accept;
    logic                illegal;

    assign word_q = addr_q[ADDR_W+1:2];

    // A new address phase is only taken while this slave is showing ready;
    // in WAIT/ERR1 the bus holds hready low anyway.
    assign accept     = hsel && hready && htrans[1];
    assign can_accept = (state_q == S_IDLE) || (state_q == S_DATA) || (state_q == S_ERR2);

    assign illegal = (hsize > 3'b010)
                   || ((hsize == 3'b001) && haddr[0])
                   || ((hsize == 3'b010) && (haddr[1:0] != 2'b00))
                   || (|haddr[31:ADDR_W+2]);

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            size_q  <= size_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        write_d   = write_q;
        size_d    = size_q;
        hreadyout = 1'b1;
        hresp     = 1'b0;

        case (state_q)
            S_IDLE: ;
            S_WAIT: begin
                hreadyout = 1'b0;
                // Counter is loaded with WAIT_STATES, so leaving at 1 gives
                // exactly WAIT_STATES low-ready cycles.
                if (cnt_q <= 3'd1) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_DATA: state_d = S_IDLE;
            S_ERR1: begin
                hreadyout = 1'b0;
                hresp     = 1'b1;
                state_d   = S_ERR2;
            end
            S_ERR2: begin
                hresp   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Pipelined acceptance overrides the default return to IDLE.
        if (can_accept && accept) begin
            addr_d  = haddr[ADDR_W+1:0];
            write_d = hwrite;
            size_d  = hsize[1:0];
            if (illegal) begin
                state_d = S_ERR1;
            end else if (WAIT_STATES > 0) begin
                state_d = S_WAIT;
                cnt_d   = WS_L;
            end else begin
                state_d = S_DATA;
            end
        end
    end

    // Little-endian lane enables for the registered transfer.
    always_comb begin
        case (size_q)
            2'b00:   be = 4'b0001 << addr_q[1:0];
            2'b01:   be = addr_q[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
    end

    // Memory is deliberately not reset. The commit is gated by state_q, which
    // resets asynchronously, so a reset mid-transfer drops the pending write.
    always_ff @(posedge hclk) begin
        if ((state_q == S_DATA) && write_q) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[word_q][i*8 +: 8] <= hwdata[i*8 +: 8];
                end
            end
        end
    end

    // Combinational read: a write committed at the end of its data phase is
    // visible to any following read data phase without extra wait.
    assign hrdata = ((state_q == S_DATA) && !write_q) ? mem[word_q] : 32'h0;

endmodule

// File: tb/tb_ahb_slave_mem.sv
// tb/tb_ahb_slave_mem.sv - scoreboard bench for ahb_slave_mem with WAIT_STATES=0 and WAIT_STATES=1 instances
module tb_ahb_slave_mem;

    localparam logic [1:0] ID = 2'b00;
    localparam logic [1:0] BU = 2'b01;
    localparam logic [1:0] NS = 2'b10;
    localparam logic [2:0] SB = 3'b000;
    localparam logic [2:0] SH = 3'b001;
    localparam logic [2:0] SW = 3'b010;

    typedef struct {
        bit          rst;
        int          dut;
        bit          sel;
        logic [1:0]  tr;
        bit          wr;
        logic [2:0]  sz;
        logic [31:0] ad;
        logic [31:0] wd;
        bit          rdy;
        bit          e_ro;
        bit          e_rs;
        logic [31:0] e_rd;
        string       name;
    } vec_t;

    typedef struct {
        int          dut;
        bit          ro;
        bit          rs;
        logic [31:0] rd;
        string       name;
    } exp_t;

    logic        hclk;
    logic        hresetn;
    logic        cur_sel;
    int          cur_dut;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        hready;
    logic        hsel0, hsel1;
    logic [31:0] hrdata0, hrdata1;
    logic        hreadyout0, hreadyout1;
    logic        hresp0, hresp1;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   checks;
    int   errors;

    assign hsel0 = cur_sel && (cur_dut == 0);
    assign hsel1 = cur_sel && (cur_dut == 1);

    ahb_slave_mem #(.ADDR_W(8), .WAIT_STATES(0)) u_dut0 (
        .hclk(hclk), .hresetn(hresetn), .hsel(hsel0), .haddr(haddr),
        .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata),
        .hready(hready), .hrdata(hrdata0), .hreadyout(hreadyout0), .hresp(hresp0)
    );

    ahb_slave_mem #(.ADDR_W(8), .WAIT_STATES(1)) u_dut1 (
        .hclk(hclk), .hresetn(hresetn), .hsel(hsel1), .haddr(haddr),
        .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata),
        .hready(hready), .hrdata(hrdata1), .hreadyout(hreadyout1), .hresp(hresp1)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    task automatic v(input bit rst, input int dut, input bit sel, input logic [1:0] tr,
                     input bit wr, input logic [2:0] sz, input logic [31:0] ad,
                     input logic [31:0] wd, input bit rdy, input bit e_ro, input bit e_rs,
                     input logic [31:0] e_rd, input string name);
        vec_t r;
        r.rst = rst; r.dut = dut; r.sel = sel; r.tr = tr; r.wr = wr; r.sz = sz;
        r.ad = ad; r.wd = wd; r.rdy = rdy; r.e_ro = e_ro; r.e_rs = e_rs;
        r.e_rd = e_rd; r.name = name;
        vecs.push_back(r);
    endtask

    task automatic chk(input string name, input string field, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got 0x%08h expected 0x%08h", name, field, act, exp);
        end
    endtask

    // Monitor: one expected entry per clock cycle, compared mid-cycle.
    always @(negedge hclk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            if (e.dut == 0) begin
                chk(e.name, "hreadyout", {31'b0, hreadyout0}, {31'b0, e.ro});
                chk(e.name, "hresp",     {31'b0, hresp0},     {31'b0, e.rs});
                chk(e.name, "hrdata",    hrdata0,             e.rd);
            end else begin
                chk(e.name, "hreadyout", {31'b0, hreadyout1}, {31'b0, e.ro});
                chk(e.name, "hresp",     {31'b0, hresp1},     {31'b0, e.rs});
                chk(e.name, "hrdata",    hrdata1,             e.rd);
            end
        end
    end

    initial begin
        checks  = 0;
        errors  = 0;
        hresetn = 1'b0;
        cur_sel = 1'b0;
        cur_dut = 1;
        haddr   = '0;
        htrans  = ID;
        hwrite  = 1'b0;
        hsize   = SB;
        hwdata  = '0;
        hready  = 1'b1;

        // ---------------- WAIT_STATES=1 instance ----------------
        //  rst d sel tr  wr sz  addr          wdata         rdy ro rs rdata
        v(1, 1, 0, ID, 0, SB, 32'h0,         32'h0,         1, 1, 0, 32'h0,         "reset");
        v(0, 1, 0, ID, 0, SB, 32'h0,         32'h0,         1, 1, 0, 32'h0,         "idle");
        v(0, 1, 1, NS, 1, SW, 32'h00,        32'h0,         1, 1, 0, 32'h0,         "w0_addr");
        v(0, 1, 0, ID, 0, SB, 32'h0,         32'h11223344,  0, 0, 0, 32'h0,         "w0_wait");
        v(0, 1, 0, ID, 0, SB, 32'h0,         32'h11223344,  1, 1, 0, 32'h0,         "w0_data");
        v(0, 1, 1, NS, 1, SW, 32'h10,        32'h0,         1, 1, 0, 32'h0,         "w10_addr");
        v(0, 1, 0, ID, 0, SB, 32'h0,         32'hDEADBEEF,  0, 0, 0, 32'h0,         "w10_wait");
        v(0, 1, 1, NS, 0, SW, 32'h10,        32'hDEADBEEF,  1, 1, 0, 32'h0,         "w10_data");
        v(0, 1, 0, ID, 0, SB, 32'h0,         32'h0,         0, 0, 0, 32'h0,         "r10_wait");
        v(0, 1, 0, ID, 0, SB, 32'h0,         32'h0,         1, 1, 0, 32'hDEADBEEF,  "r10_data");
        // misaligned word write, then a read accepted during ERR2
        v(0, 1, 1, NS, 1, SW, 32'h02,        32'h0,         1, 1, 0, 32'h0,         "mis_addr");
        v(0, 1, 0, ID, 0, SB, 32'h0,         32'hFFFFFFFF,  0, 0, 1, 32'h0,         "mis_err1");
        v(0, 1, 1, NS, 0, SW, 32'h00,        32'hFFFFFFFF,  1, 1, 1, 32'h0,         "mis_err2");
        v(0, 1, 0, ID, 0, SB, 32'h0,         32'h0,         0, 0, 0, 32'h0,         "r0_wait");
        v(0, 1, 0, ID, 0, SB, 32'h0,         32'h0,         1, 1, 0, 32'h11223344,  "r0_data");
        // out-of-range address, then hsize=011 accepted during ERR2
        v(0, 1, 1, NS, 0, SW, 32'h400,       32'h0,         1, 1, 0, 32'h0,         "oor_addr");
        v(0, 1, 0, ID, 0, SB, 32'h0,         32'h0,         0, 0, 1, 32'h0,         "oor_err1");
        v(0, 1, 1, NS, 0, 3'b011, 32'h00,    32'h0,         1, 1, 1, 32'h0,         "oor_err2");
        v(0, 1, 0, ID, 0, SB, 32'h0,         32'h0,         0, 0, 1, 32'h0,         "sz3_err1");
        v(0, 1, 0, ID, 0, SB, 32'h0,         32'h0,         1, 1, 1, 32'h0,         "sz3_err2");
        v(0, 1, 1, NS, 1, SH, 32'h11,        32'h0,         1, 1, 0, 32'h0,         "hmis_addr");
        v(0, 1, 0, ID, 0, SB, 32'h0,         32'h0,         0, 0, 1, 32'h0,         "hmis_err1");
        v(0, 1, 0, ID, 0, SB, 32'h0,         32'h0,         1, 1, 1, 32'h0,         "hmis_err2");
        // transfers that must not be accepted
        v(0, 1, 1, BU, 1, SW, 32'h10,        32'h0,         1, 1, 0, 32'h0,         "busy");
        v(0, 1, 0, NS, 1, SW, 32'h10,        32'h0,         1, 1, 0, 32'h0,         "nosel");
        v(0, 1, 1, NS, 1, SW, 32'h10,        32'h0,         0, 1, 0, 32'h0,         "nordy");
        v(0, 1, 0, ID, 0, SB, 32'h0,         32'h0,         1, 1, 0, 32'h0,         "still_idle");
        // upper halfword write merges into 0xDEADBEEF
        v(0, 1, 1, NS, 1, SH, 32'h12,        32'h0,         1, 1, 0, 32'h0,         "wh_addr");
        v(0, 1, 0, ID, 0, SB, 32'h0,         32'h5A5A0000,  0, 0, 0, 32'h0,         "wh_wait");
        v(0, 1, 1, NS, 0, SW, 32'h10,        32'h5A5A0000,  1, 1, 0, 32'h0,         "wh_data");
        v(0, 1, 0, ID, 0, SB, 32'h0,         32'h0,         0, 0, 0, 32'h0,         "rh_wait");
        v(0, 1, 0, ID, 0, SB, 32'h0,         32'h0,         1, 1, 0, 32'h5A5ABEEF,  "rh_data");
        // reset during WAIT of a write: write is dropped
        v(0, 1, 1, NS, 1, SW, 32'h10,        32'h0,         1, 1, 0, 32'h0,         "wr_rst_addr");
        v(1, 1, 0, ID, 0, SB, 32'h0,         32'hCAFEF00D,  1, 1, 0, 32'h0,         "wr_rst_wait");
        v(0, 1, 1, NS, 0, SW, 32'h10,        32'h0,         1, 1, 0, 32'h0,         "rr_addr");
        v(0, 1, 0, ID, 0, SB, 32'h0,         32'h0,         0, 0, 0, 32'h0,         "rr_wait");
        v(0, 1, 0, ID, 0, SB, 32'h0,         32'h0,         1, 1, 0, 32'h5A5ABEEF,  "rr_data");

        // ---------------- WAIT_STATES=0 instance ----------------
        // Write data is presented on its byte lane (0xAA on lane 1 for 0x21).
        v(0, 0, 1, NS, 1, SW, 32'h20,        32'h0,         1, 1, 0, 32'h0,         "z_w20_addr");
        v(0, 0, 1, NS, 1, SB, 32'h21,        32'h0,         1, 1, 0, 32'h0,         "z_w20_data");
        v(0, 0, 1, NS, 0, SW, 32'h20,        32'h0000AA00,  1, 1, 0, 32'h0,         "z_wb21_data");
        v(0, 0, 1, NS, 1, SH, 32'h22,        32'h0,         1, 1, 0, 32'h0000AA00,  "z_r20_data");
        v(0, 0, 1, NS, 1, SB, 32'h23,        32'hBEEF0000,  1, 1, 0, 32'h0,         "z_wh22_data");
        v(0, 0, 1, NS, 0, SW, 32'h20,        32'h77000000,  1, 1, 0, 32'h0,         "z_wb23_data");
        v(0, 0, 0, ID, 0, SB, 32'h0,         32'h0,         1, 1, 0, 32'h77EFAA00,  "z_r20b_data");
        v(0, 0, 1, NS, 1, SW, 32'h22,        32'h0,         1, 1, 0, 32'h0,         "z_mis_addr");
        v(0, 0, 0, ID, 0, SB, 32'h0,         32'hFFFFFFFF,  0, 0, 1, 32'h0,         "z_mis_err1");
        v(0, 0, 1, NS, 0, SW, 32'h20,        32'hFFFFFFFF,  1, 1, 1, 32'h0,         "z_mis_err2");
        v(0, 0, 0, ID, 0, SB, 32'h0,         32'h0,         1, 1, 0, 32'h77EFAA00,  "z_r20c_data");
        v(0, 0, 0, ID, 0, SB, 32'h0,         32'h0,         1, 1, 0, 32'h0,         "z_idle");

        foreach (vecs[i]) begin
            exp_t e;
            @(posedge hclk);
            #1;
            hresetn = !vecs[i].rst;
            cur_dut = vecs[i].dut;
            cur_sel = vecs[i].sel;
            htrans  = vecs[i].tr;
            hwrite  = vecs[i].wr;
            hsize   = vecs[i].sz;
            haddr   = vecs[i].ad;
            hwdata  = vecs[i].wd;
            hready  = vecs[i].rdy;
            e.dut  = vecs[i].dut;
            e.ro   = vecs[i].e_ro;
            e.rs   = vecs[i].e_rs;
            e.rd   = vecs[i].e_rd;
            e.name = vecs[i].name;
            exp_q.push_back(e);
        end

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge hclk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
